sync_count_ctrl: RTL

//  Sequencing controller for the synchronous T-flip-flop up counter. Runs an

---
 rtl/sync_count_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/sync_count_ctrl.sv
// Sequencing controller around a WIDTH-bit synchronous counter: base->terminal runs, one-shot or auto-reload.
// Optional define SYNCNT_DIR_EN adds dir_i (sampled at start) for down-counting.
module sync_count_ctrl #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             pause_i,
   input  logic             stop_i,
   input  logic             mode_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] term_i,
`ifdef SYNCNT_DIR_EN
   input  logic             dir_i,
`endif
   output logic [WIDTH-1:0] cnt_o,
   output logic             busy_o,
   output logic             tc_o,
   output logic             done_o
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] base_q;
   logic [WIDTH-1:0] term_q, term_d;
   logic             mode_q, mode_d;
   logic             tc_d;
   logic [WIDTH-1:0] cnt_step;

`ifdef SYNCNT_DIR_EN
   logic dir_q, dir_d;
   assign cnt_step = dir_q ? cnt_o - WIDTH'(1) : cnt_o + WIDTH'(1);
`else
   assign cnt_step = cnt_o + WIDTH'(1);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_o;
      term_d  = term_q;
      mode_d  = mode_q;
      tc_d    = 1'b0;
`ifdef SYNCNT_DIR_EN
      dir_d   = dir_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (stop_i) begin
               state_d = IDLE;
            end else if (start_i) begin
               // Start uses the base register as it stood before any same-cycle load.
               state_d = RUN;
               cnt_d   = base_q;
               term_d  = term_i;
               mode_d  = mode_i;
`ifdef SYNCNT_DIR_EN
               dir_d   = dir_i;
`endif
            end
         end
         RUN: begin
            if (stop_i) begin
               state_d = IDLE;
            end else if (pause_i) begin
               state_d = PAUSE;
            end else if (cnt_o == term_q) begin
               tc_d = 1'b1;
               if (mode_q) cnt_d   = base_q;
               else        state_d = DONE;
            end else begin
               cnt_d = cnt_step;
            end
         end
         PAUSE: begin
            if (stop_i)        state_d = IDLE;
            else if (!pause_i) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_o   <= '0;
         base_q  <= '0;
         term_q  <= '0;
         mode_q  <= 1'b0;
         busy_o  <= 1'b0;
         tc_o    <= 1'b0;
         done_o  <= 1'b0;
`ifdef SYNCNT_DIR_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_o   <= cnt_d;
         term_q  <= term_d;
         mode_q  <= mode_d;
         tc_o    <= tc_d;
         busy_o  <= (state_d == RUN) || (state_d == PAUSE);
         done_o  <= (state_d == DONE);
         if (load_i) base_q <= load_val_i;
`ifdef SYNCNT_DIR_EN
         dir_q   <= dir_d;
`endif
      end
   end

endmodule
